max7219_seq: RTL and testbench
==============================

MAX7219_SEQ -- requirements
Module: max7219_seq

Interface
REQ-001 Parameter REFRESH_DIV, default 2_500_000: clk cycles between forced refresh frames (50 ms at 50 MHz).
REQ-002 Parameter ACK_TIMEOUT, default 4096: max clk cycles spi_req may stay high without spi_ack.
REQ-003 clk  in  1  single system clock (50 MHz); all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 time_data  in  32  8 BCD digits; digit k = time_data[4k+3:4k], k=0..7.
REQ-006 dp_mask  in  8  decimal point per digit; bit k lights DP of digit k.
REQ-007 intensity  in  4  MAX7219 brightness code.
REQ-008 cfg_update  in  1  one-cycle pulse: re-send intensity.
REQ-009 spi_req  out  1  word-valid request to the SPI word transmitter.
REQ-010 spi_word  out  16  MAX7219 frame {addr[15:8], data[7:0]}.
REQ-011 spi_ack  in  1  one-cycle pulse: word shifted out and CS released.
REQ-012 init_done  out  1  high once the init sequence completes.
REQ-013 busy  out  1  high while any word is outstanding or queued in a sequence.
REQ-014 err  out  1  sticky ack-timeout flag.

Function
REQ-015 FSM states: INIT, WAIT_INIT, IDLE, REFRESH, WAIT_REF, CFG, WAIT_CFG.
REQ-016 INIT issues, in order: 0x0F00 (test off), 0x0B07 (scan 8), 0x09FF (BCD decode all), {0x0A, 4'h0, intensity}, 0x0C01 (normal op).
REQ-017 After ack of the 5th init word: init_done rises the next cycle, FSM goes to IDLE, first refresh frame is forced.
REQ-018 Refresh frame = 8 words, k=0..7 ascending: {k+1 (8 bits), dp_mask[k], 3'b000, digit k}.
REQ-019 time_data and dp_mask are snapshotted on the cycle a frame starts; the frame uses only the snapshot.
REQ-020 In IDLE a frame starts when {time_data, dp_mask} differs from the last sent snapshot, or the refresh counter reaches REFRESH_DIV-1.
REQ-021 Refresh counter clears at every frame start; it counts in all states after init_done.
REQ-022 cfg_update sets a pending flag in any state; CFG sends one word {0x0A, 4'h0, intensity} and clears the flag.
REQ-023 Pulses arriving while the flag is already set merge into the pending update.
REQ-024 A frame in progress is never interrupted; CFG runs only from IDLE.
REQ-025 If a CFG request and a refresh trigger occur together in IDLE, CFG goes first and the refresh follows.
REQ-026 cfg_update during init is held and serviced after init_done.
REQ-027 Handshake: spi_req and spi_word are held stable from spi_req rise until the cycle spi_ack is sampled high.
REQ-028 spi_req is low the cycle after ack; the next spi_req rises no earlier than one cycle after that.
REQ-029 spi_ack while spi_req is low is ignored.
REQ-030 Latency: spi_req first rises the cycle after the first clock edge with rst_n sampled high.
REQ-031 Within a sequence, word n+1 is requested 2 cycles after word n's ack.
REQ-032 On ack timeout (ACK_TIMEOUT cycles of spi_req high), the current word is dropped and spi_req goes low.
REQ-033 After a timeout: err is set, init_done clears, INIT restarts from word 0.
REQ-034 busy = spi_req OR FSM not in IDLE.

Reset
REQ-035 rst_n low at a clock edge forces: spi_req=0, spi_word=16'h0000, init_done=0, busy=0, err=0, FSM=INIT, pending flag=0, counters=0, snapshot=0.
REQ-036 Reset mid-word abandons the transfer; after release the full init sequence is re-sent.

Structure
REQ-037 MAX7219 register addresses (0x01-0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x0F), the init-word table, and the FSM state encoding go in the shared package max7219_pkg.
REQ-038 The SPI shifter is the separate sub-module spi16_tx (16-bit MSB-first, CS framing, req/ack port); max7219_seq does not contain it.

Verification
REQ-039 Reset release, ack 3 cycles after each req -> words 0F00, 0B07, 09FF, 0A0<intensity>, 0C01, then 0100|d0 ... 0800|d7; init_done high after the 5th ack.
REQ-040 time_data=32'h12345678, dp_mask=8'h04 steady -> frame words 0108, 0207, 0386, 0405, 0504, 0603, 0702, 0801; no further frame until REFRESH_DIV cycles elapse.
REQ-041 time_data changes during word 3 of a frame -> the frame completes with old digits; the next frame starts immediately with new digits.
REQ-042 cfg_update pulsed twice mid-frame with intensity=4'hA -> exactly one 0x0A0A word after the frame, before the next frame.
REQ-043 spi_ack withheld -> after ACK_TIMEOUT cycles: err=1, init_done=0, spi_req low, then 0x0F00 requested again.
REQ-044 rst_n low for 1 cycle during WAIT_REF -> all outputs at reset values next cycle; init restarts with 0x0F00.

Source files
------------

// File: rtl/max7219_pkg.sv
// max7219_pkg: MAX7219 register map, init-word table and sequencer state encoding.
package max7219_pkg;

   localparam logic [7:0] ADDR_DIGIT0    = 8'h01;
   localparam logic [7:0] ADDR_DECODE    = 8'h09;
   localparam logic [7:0] ADDR_INTENSITY = 8'h0A;
   localparam logic [7:0] ADDR_SCAN      = 8'h0B;
   localparam logic [7:0] ADDR_SHUTDOWN  = 8'h0C;
   localparam logic [7:0] ADDR_TEST      = 8'h0F;

   localparam logic [2:0] INIT_LAST  = 3'd4;
   localparam logic [2:0] FRAME_LAST = 3'd7;

   typedef enum logic [2:0] {INIT, WAIT_INIT, IDLE, REFRESH, WAIT_REF, CFG, WAIT_CFG} state_t;

   // Power-up sequence; intensity is the only live field.
   function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
      return idx == 3'd0 ? {ADDR_TEST, 8'h00} :
             idx == 3'd1 ? {ADDR_SCAN, 8'h07} :
             idx == 3'd2 ? {ADDR_DECODE, 8'hFF} :
             idx == 3'd3 ? {ADDR_INTENSITY, 4'h0, intensity} :
                           {ADDR_SHUTDOWN, 8'h01};
   endfunction

   function automatic logic [15:0] digit_word(input logic [2:0] k, input logic [31:0] td, input logic [7:0] dp);
      return {ADDR_DIGIT0 + 8'(k), dp[k], 3'b000, td[{k, 2'b00} +: 4]};
   endfunction

endpackage

// File: rtl/max7219_seq.sv
// max7219_seq: MAX7219 init / refresh / intensity sequencer driving a req/ack SPI word transmitter.
module max7219_seq
   import max7219_pkg::*;
#(
   parameter int REFRESH_DIV = 2_500_000,
   parameter int ACK_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] time_data,
   input  logic [7:0]  dp_mask,
   input  logic [3:0]  intensity,
   input  logic        cfg_update,
   output logic        spi_req,
   output logic [15:0] spi_word,
   input  logic        spi_ack,
   output logic        init_done,
   output logic        busy,
   output logic        err
);

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] snap_td_q, snap_td_d;
   logic [7:0]  snap_dp_q, snap_dp_d;
   logic [31:0] rcnt_q, rcnt_d;
   logic [31:0] tcnt_q, tcnt_d;
   logic [15:0] word_q, word_d;
   logic        req_q, req_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
   logic        pend_q, pend_d, force_q, force_d;
   logic        acked, tout, trig;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      snap_td_d = snap_td_q;
      snap_dp_d = snap_dp_q;
      word_d    = word_q;
      req_d     = req_q;
      done_d    = done_q;
      err_d     = err_q;
      force_d   = force_q;
      pend_d    = pend_q | cfg_update;
      acked     = req_q & spi_ack;
      tout      = req_q & ~spi_ack & (tcnt_q == 32'(ACK_TIMEOUT - 1));
      trig      = force_q | ({time_data, dp_mask} != {snap_td_q, snap_dp_q}) | (rcnt_q >= 32'(REFRESH_DIV - 1));
      tcnt_d    = req_q ? tcnt_q + 32'd1 : 32'd0;
      // Saturate so a trigger deferred behind a CFG word is not lost.
      rcnt_d    = !done_q ? rcnt_q : (rcnt_q >= 32'(REFRESH_DIV - 1)) ? rcnt_q : rcnt_q + 32'd1;
      if (tout) begin
         req_d   = 1'b0;
         err_d   = 1'b1;
         done_d  = 1'b0;
         idx_d   = 3'd0;
         state_d = INIT;
      end else begin
         case (state_q)
            INIT: begin
               req_d   = 1'b1;
               word_d  = init_word(idx_q, intensity);
               state_d = WAIT_INIT;
            end
            WAIT_INIT: if (acked) begin
               req_d   = 1'b0;
               idx_d   = idx_q == INIT_LAST ? 3'd0 : idx_q + 3'd1;
               done_d  = idx_q == INIT_LAST;
               force_d = idx_q == INIT_LAST;
               state_d = idx_q == INIT_LAST ? IDLE : INIT;
            end
            IDLE: if (pend_q) state_d = CFG;
               else if (trig) begin
                  snap_td_d = time_data;
                  snap_dp_d = dp_mask;
                  rcnt_d    = 32'd0;
                  force_d   = 1'b0;
                  idx_d     = 3'd0;
                  state_d   = REFRESH;
               end
            REFRESH: begin
               req_d   = 1'b1;
               word_d  = digit_word(idx_q, snap_td_q, snap_dp_q);
               state_d = WAIT_REF;
            end
            WAIT_REF: if (acked) begin
               req_d   = 1'b0;
               idx_d   = idx_q + 3'd1;
               state_d = idx_q == FRAME_LAST ? IDLE : REFRESH;
            end
            CFG: begin
               req_d   = 1'b1;
               word_d  = {ADDR_INTENSITY, 4'h0, intensity};
               pend_d  = cfg_update;
               state_d = WAIT_CFG;
            end
            WAIT_CFG: if (acked) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
            default: state_d = INIT;
         endcase
      end
      busy_d = req_d | (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= INIT;
         idx_q     <= 3'd0;
         snap_td_q <= 32'd0;
         snap_dp_q <= 8'd0;
         rcnt_q    <= 32'd0;
         tcnt_q    <= 32'd0;
         word_q    <= 16'h0000;
         req_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         pend_q    <= 1'b0;
         force_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         snap_td_q <= snap_td_d;
         snap_dp_q <= snap_dp_d;
         rcnt_q    <= rcnt_d;
         tcnt_q    <= tcnt_d;
         word_q    <= word_d;
         req_q     <= req_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         pend_q    <= pend_d;
         force_q   <= force_d;
      end
   end

   assign spi_req   = req_q;
   assign spi_word  = word_q;
   assign init_done = done_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_max7219_seq.sv
// tb_max7219_seq: directed checks of init, refresh, cfg merge, ack timeout and mid-word reset.
module tb_max7219_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] time_data = 32'h12345678;
   logic [7:0]  dp_mask = 8'h04;
   logic [3:0]  intensity = 4'h5;
   logic        cfg_update = 1'b0;
   logic        spi_ack = 1'b0;
   logic        spi_req, init_done, busy, err;
   logic [15:0] spi_word;
   int          checks = 0;
   int          errors = 0;

   max7219_seq #(.REFRESH_DIV(300), .ACK_TIMEOUT(20)) dut (
      .clk(clk), .rst_n(rst_n), .time_data(time_data), .dp_mask(dp_mask),
      .intensity(intensity), .cfg_update(cfg_update), .spi_req(spi_req),
      .spi_word(spi_word), .spi_ack(spi_ack), .init_done(init_done),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input int bound);
      int n = 0;
      while (spi_req !== 1'b1 && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_seen", {31'd0, spi_req}, 32'd1);
   endtask

   // Word must stay held until acked 3 cycles after req is seen; req drops right after ack.
   task automatic xfer(input string tag, input logic [15:0] exp);
      wait_req(200);
      chk(tag, {16'd0, spi_word}, {16'd0, exp});
      repeat (2) begin
         @(posedge clk); #1;
         chk({tag, "_hold"}, {15'd0, spi_req, spi_word}, {15'd0, 1'b1, exp});
      end
      spi_ack = 1'b1;
      @(posedge clk); #1;
      spi_ack = 1'b0;
      chk({tag, "_drop"}, {31'd0, spi_req}, 32'd0);
   endtask

   task automatic pulse_cfg();
      cfg_update = 1'b1;
      @(posedge clk); #1;
      cfg_update = 1'b0;
   endtask

   initial begin
      logic [15:0] init_exp [5];
      logic        seen;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {12'd0, spi_req, init_done, busy, err, spi_word}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("first_req", {15'd0, spi_req, spi_word}, {15'd0, 1'b1, 16'h0F00});
      chk("busy_init", {31'd0, busy}, 32'd1);
      init_exp = '{16'h0F00, 16'h0B07, 16'h09FF, 16'h0A05, 16'h0C01};
      for (int i = 0; i < 5; i++) begin
         chk("init_done_low", {31'd0, init_done}, 32'd0);
         xfer("init", init_exp[i]);
      end
      chk("init_done_high", {31'd0, init_done}, 32'd1);

      xfer("f1_d0", 16'h0108); xfer("f1_d1", 16'h0207); xfer("f1_d2", 16'h0386); xfer("f1_d3", 16'h0405);
      xfer("f1_d4", 16'h0504); xfer("f1_d5", 16'h0603); xfer("f1_d6", 16'h0702); xfer("f1_d7", 16'h0801);
      seen = 1'b0;
      repeat (200) begin
         @(posedge clk); #1;
         if (spi_req) seen = 1'b1;
      end
      chk("no_early_frame", {31'd0, seen}, 32'd0);
      chk("idle_not_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 8; k++) begin
         logic [31:0] td = 32'h12345678;
         xfer("periodic", {8'(k + 1), dp_mask[k], 3'b000, td[4*k +: 4]});
      end

      time_data = 32'h11111111; dp_mask = 8'h00;
      xfer("chg_d0", 16'h0101); xfer("chg_d1", 16'h0201);
      time_data = 32'h98765432;
      for (int k = 2; k < 8; k++) xfer("old_digits", {8'(k + 1), 8'h01});
      for (int k = 0; k < 8; k++) xfer("new_digits", {8'(k + 1), 4'h0, 4'(k + 2)});

      intensity = 4'hA; time_data = 32'h00000000; dp_mask = 8'hFF;
      xfer("cf_d0", 16'h0180);
      pulse_cfg();
      xfer("cf_d1", 16'h0280); xfer("cf_d2", 16'h0380);
      time_data = 32'h00000001;
      xfer("cf_d3", 16'h0480);
      pulse_cfg();
      for (int k = 4; k < 8; k++) xfer("cf_rest", {8'(k + 1), 8'h80});
      xfer("cfg_word", 16'h0A0A);
      xfer("after_cfg_d0", 16'h0181);
      for (int k = 1; k < 8; k++) xfer("after_cfg", {8'(k + 1), 8'h80});

      time_data = 32'h00000000;
      wait_req(50);
      chk("to_word", {16'd0, spi_word}, 32'h0180);
      repeat (19) @(posedge clk);
      #1;
      chk("to_still_req", {31'd0, spi_req}, 32'd1);
      @(posedge clk); #1;
      chk("to_outs", {28'd0, spi_req, err, init_done, busy}, {28'd0, 4'b0101});
      xfer("reinit0", 16'h0F00);
      chk("err_sticky", {31'd0, err}, 32'd1);
      xfer("reinit1", 16'h0B07); xfer("reinit2", 16'h09FF); xfer("reinit3", 16'h0A0A); xfer("reinit4", 16'h0C01);
      chk("reinit_done", {31'd0, init_done}, 32'd1);

      wait_req(50);
      chk("rst_mid_word", {16'd0, spi_word}, 32'h0180);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst2_outs", {12'd0, spi_req, init_done, busy, err, spi_word}, 32'd0);
      @(posedge clk); #1;
      chk("rst2_req", {14'd0, busy, spi_req, spi_word}, {14'd0, 2'b11, 16'h0F00});
      xfer("rst2_init0", 16'h0F00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
